// File: rtl/axi4_b_sender.sv
// Write-response (B) channel stage of the RAB slave port.
// Forwards master-side B responses and generates local B responses for AW
// bursts that the RAB dropped. A dropped burst is answered only once its
// write data has been consumed. Both sources share one registered output
// stage and are arbitrated round-robin.
//
// Ports:
//   axi4_aclk, axi4_arstn           clock, synchronous active-low reset
//   drop, drop_id/user/prefetch     capture one dropped AW transaction
//   drop_wdone                      W sender finished discarding one dropped burst
//   wlast_received / response_sent  L2 handshake with the W sender (ENABLE_L2TLB=1)
//   stall_aw                        drop FIFO full
//   drop_overflow                   sticky: drop lost because the FIFO was full
//   m_axi4_b*                       master-side B channel (input side)
//   s_axi4_b*                       slave-side B channel (registered output)
module axi4_b_sender #(
    parameter int unsigned AXI_ID_WIDTH    = 10,
    parameter int unsigned AXI_USER_WIDTH  = 2,
    parameter int unsigned ENABLE_L2TLB    = 0,
    parameter int unsigned DROP_FIFO_DEPTH = 4
) (
    input  logic                      axi4_aclk,
    input  logic                      axi4_arstn,
    input  logic                      drop,
    input  logic [AXI_ID_WIDTH-1:0]   drop_id,
    input  logic [AXI_USER_WIDTH-1:0] drop_user,
    input  logic                      drop_prefetch,
    input  logic                      drop_wdone,
    input  logic                      wlast_received,
    output logic                      response_sent,
    output logic                      stall_aw,
    output logic                      drop_overflow,
    input  logic [AXI_ID_WIDTH-1:0]   m_axi4_bid,
    input  logic [1:0]                m_axi4_bresp,
    input  logic [AXI_USER_WIDTH-1:0] m_axi4_buser,
    input  logic                      m_axi4_bvalid,
    output logic                      m_axi4_bready,
    output logic [AXI_ID_WIDTH-1:0]   s_axi4_bid,
    output logic [1:0]                s_axi4_bresp,
    output logic [AXI_USER_WIDTH-1:0] s_axi4_buser,
    output logic                      s_axi4_bvalid,
    input  logic                      s_axi4_bready
);

    localparam int unsigned PTR_W = (DROP_FIFO_DEPTH > 2) ? $clog2(DROP_FIFO_DEPTH) : 1;
    localparam int unsigned CNT_W = PTR_W + 1;
    localparam bit          L2_EN = (ENABLE_L2TLB != 0);

    typedef struct packed {
        logic [AXI_ID_WIDTH-1:0]   id;
        logic [AXI_USER_WIDTH-1:0] user;
        logic                      prefetch;
    } drop_entry_t;

    drop_entry_t      fifo_mem [DROP_FIFO_DEPTH];
    drop_entry_t      head;
    logic [PTR_W-1:0] wr_ptr;
    logic [PTR_W-1:0] rd_ptr;
    logic [CNT_W-1:0] fifo_count;
    logic [CNT_W-1:0] count_next;
    logic [CNT_W-1:0] credit;
    logic [CNT_W-1:0] credit_next;
    logic             last_fwd;

    logic fifo_empty;
    logic credit_avail;
    logic wlast_ok;
    logic loc_req;
    logic load_en;
    logic grant_loc;
    logic push;
    logic pop;
    logic pop_credit;

    // Release and arbitration decode.
    assign fifo_empty   = (fifo_count == '0);
    assign head         = fifo_mem[rd_ptr];
    // drop_wdone is usable in the cycle it arrives, so the response follows it directly.
    assign credit_avail = (credit != '0) | drop_wdone;
    // wlast_received is still high during the response_sent cycle; it must not release a second entry.
    assign wlast_ok     = L2_EN & wlast_received & ~response_sent;
    assign loc_req      = ~fifo_empty & (credit_avail | wlast_ok);
    assign load_en      = ~s_axi4_bvalid | s_axi4_bready;
    // last_fwd=0 after reset, so the forward path wins the first contention.
    assign grant_loc    = loc_req & (~m_axi4_bvalid | last_fwd);
    assign m_axi4_bready = load_en & ~grant_loc;
    assign pop          = load_en & grant_loc;
    assign pop_credit   = pop & credit_avail;
    // stall_aw is the registered full flag; a pop in the same cycle frees a slot.
    assign push         = drop & (~stall_aw | pop);

    // Next FIFO occupancy and saturating wdone credit.
    always_comb begin
        count_next  = fifo_count + CNT_W'(push) - CNT_W'(pop);
        credit_next = credit;
        if (drop_wdone && !pop_credit) begin
            if (credit != CNT_W'(DROP_FIFO_DEPTH)) begin
                credit_next = credit + CNT_W'(1);
            end
        end else if (!drop_wdone && pop_credit) begin
            credit_next = credit - CNT_W'(1);
        end
    end

    // Drop FIFO storage; validity is tracked by the pointers only.
    always_ff @(posedge axi4_aclk) begin
        if (push) begin
            fifo_mem[wr_ptr] <= '{id: drop_id, user: drop_user, prefetch: drop_prefetch};
        end
    end

    // FIFO control, credit and status flags.
    always_ff @(posedge axi4_aclk) begin
        if (!axi4_arstn) begin
            wr_ptr        <= '0;
            rd_ptr        <= '0;
            fifo_count    <= '0;
            credit        <= '0;
            stall_aw      <= 1'b0;
            drop_overflow <= 1'b0;
            response_sent <= 1'b0;
        end else begin
            if (push) wr_ptr <= wr_ptr + PTR_W'(1);
            if (pop)  rd_ptr <= rd_ptr + PTR_W'(1);
            fifo_count    <= count_next;
            credit        <= credit_next;
            stall_aw      <= (count_next == CNT_W'(DROP_FIFO_DEPTH));
            drop_overflow <= drop_overflow | (drop & ~push);
            response_sent <= L2_EN & pop & ~credit_avail;
        end
    end

    // Output register and round-robin history.
    always_ff @(posedge axi4_aclk) begin
        if (!axi4_arstn) begin
            s_axi4_bvalid <= 1'b0;
            s_axi4_bid    <= '0;
            s_axi4_bresp  <= 2'b00;
            s_axi4_buser  <= '0;
            last_fwd      <= 1'b0;
        end else if (load_en) begin
            if (grant_loc) begin
                s_axi4_bvalid <= 1'b1;
                s_axi4_bid    <= head.id;
                s_axi4_bresp  <= head.prefetch ? 2'b00 : 2'b10;
                s_axi4_buser  <= head.user;
                last_fwd      <= 1'b0;
            end else if (m_axi4_bvalid) begin
                s_axi4_bvalid <= 1'b1;
                s_axi4_bid    <= m_axi4_bid;
                s_axi4_bresp  <= m_axi4_bresp;
                s_axi4_buser  <= m_axi4_buser;
                last_fwd      <= 1'b1;
            end else begin
                s_axi4_bvalid <= 1'b0;
            end
        end
    end

endmodule
